// File: rtl/vedic_pkg.sv
// Shared constants and helpers for the pipelined Vedic multiplier.
package vedic_pkg;

    localparam int unsigned VEDIC_MIN_W = 4;
    localparam int unsigned VEDIC_MAX_W = 32;

    // Two's-complement magnitude of a sign-extended value. The most negative
    // operand maps to 2^(w-1), which still fits in w unsigned bits after truncation.
    function automatic logic [VEDIC_MAX_W-1:0] vedic_mag(input logic [VEDIC_MAX_W-1:0] v);
        return v[VEDIC_MAX_W-1] ? -v : v;
    endfunction

    // Legal operand widths: a power of two inside [VEDIC_MIN_W, VEDIC_MAX_W].
    function automatic bit vedic_width_ok(input int unsigned w);
        return (w >= VEDIC_MIN_W) && (w <= VEDIC_MAX_W) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/vedic_nxn_comb.sv
// Combinational W x W unsigned Urdhva-Tiryakbhyam multiplier, recursive down to
// a 2x2 half-adder leaf.
module vedic_nxn_comb #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    if (W == 2) begin : g_leaf
        logic cross_lo;
        logic cross_hi;
        logic top;
        logic c1;

        assign cross_lo = a[1] & b[0];
        assign cross_hi = a[0] & b[1];
        assign top      = a[1] & b[1];
        // Two half adders: one on the cross terms, one folding the carry into the top term.
        assign c1       = cross_lo & cross_hi;
        assign p[0]     = a[0] & b[0];
        assign p[1]     = cross_lo ^ cross_hi;
        assign p[2]     = top ^ c1;
        assign p[3]     = top & c1;
    end else begin : g_rec
        localparam int unsigned H = W / 2;

        logic [W-1:0] ll;
        logic [W-1:0] hl;
        logic [W-1:0] lh;
        logic [W-1:0] hh;
        logic [W:0]   mid;

        vedic_nxn_comb #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
        vedic_nxn_comb #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
        vedic_nxn_comb #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
        vedic_nxn_comb #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));

        assign mid = {1'b0, hl} + {1'b0, lh};
        assign p   = {hh, ll} + {{(H - 1){1'b0}}, mid, {H{1'b0}}};
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Vedic multiplier with per-beat signed mode
// and a global-stall valid/ready handshake.
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned PW   = 2 * WIDTH;

    if (!vedic_width_ok(WIDTH)) begin : g_width_check
        $error("vedic_mult_pipe: WIDTH must be a power of two in [4, 32]");
    end

    logic             adv;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_d;

    logic [WIDTH-1:0] a1_q, b1_q;
    logic             neg1_q, v1_q;

    logic [WIDTH-1:0] ll_d, hl_d, lh_d, hh_d;
    logic [WIDTH-1:0] ll_q, hl_q, lh_q, hh_q;
    logic             neg2_q, v2_q;

    logic [WIDTH:0]   mid;
    logic [PW-1:0]    p_sum;
    logic [PW-1:0]    p_d;
    logic [PW-1:0]    p_q;
    logic             v3_q;

    // Whole pipe moves together; only a held output can stall it.
    assign adv      = !v3_q || out_ready;
    assign in_ready = adv;

    // Operand magnitudes and result sign for the capture stage.
    always_comb begin
        a_mag = in_a;
        b_mag = in_b;
        neg_d = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        if (in_signed) begin
            a_mag = WIDTH'(vedic_mag(VEDIC_MAX_W'($signed(in_a))));
            b_mag = WIDTH'(vedic_mag(VEDIC_MAX_W'($signed(in_b))));
        end
    end

    // S1: capture magnitudes, sign and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q   <= '0;
            b1_q   <= '0;
            neg1_q <= 1'b0;
            v1_q   <= 1'b0;
        end else if (adv) begin
            a1_q   <= a_mag;
            b1_q   <= b_mag;
            neg1_q <= neg_d;
            v1_q   <= in_valid;
        end
    end

    vedic_nxn_comb #(.W(HALF)) u_ll (.a(a1_q[HALF-1:0]),     .b(b1_q[HALF-1:0]),     .p(ll_d));
    vedic_nxn_comb #(.W(HALF)) u_hl (.a(a1_q[WIDTH-1:HALF]), .b(b1_q[HALF-1:0]),     .p(hl_d));
    vedic_nxn_comb #(.W(HALF)) u_lh (.a(a1_q[HALF-1:0]),     .b(b1_q[WIDTH-1:HALF]), .p(lh_d));
    vedic_nxn_comb #(.W(HALF)) u_hh (.a(a1_q[WIDTH-1:HALF]), .b(b1_q[WIDTH-1:HALF]), .p(hh_d));

    // S2: register the four half-width partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ll_q   <= '0;
            hl_q   <= '0;
            lh_q   <= '0;
            hh_q   <= '0;
            neg2_q <= 1'b0;
            v2_q   <= 1'b0;
        end else if (adv) begin
            ll_q   <= ll_d;
            hl_q   <= hl_d;
            lh_q   <= lh_d;
            hh_q   <= hh_d;
            neg2_q <= neg1_q;
            v2_q   <= v1_q;
        end
    end

    // Accumulate partial products and restore the sign.
    always_comb begin
        mid   = {1'b0, hl_q} + {1'b0, lh_q};
        p_sum = {hh_q, ll_q} + (PW'(mid) << HALF);
        p_d   = neg2_q ? -p_sum : p_sum;
    end

    // S3: registered product and output valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q  <= '0;
            v3_q <= 1'b0;
        end else if (adv) begin
            p_q  <= p_d;
            v3_q <= v2_q;
        end
    end

    assign out_p     = p_q;
    assign out_valid = v3_q;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench for vedic_mult_pipe at WIDTH = 8, 16 and 4.
module tb_vedic_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    // WIDTH = 8 instance
    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_p;

    vedic_mult_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p)
    );

    // WIDTH = 16 instance, never stalled
    logic        w16_in_valid, w16_in_ready, w16_in_signed, w16_out_valid;
    logic [15:0] w16_a, w16_b;
    logic [31:0] w16_p;

    vedic_mult_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
        .in_a(w16_a), .in_b(w16_b), .in_signed(w16_in_signed), .out_valid(w16_out_valid),
        .out_ready(1'b1), .out_p(w16_p)
    );

    // WIDTH = 4 instance, never stalled
    logic       w4_in_valid, w4_in_ready, w4_in_signed, w4_out_valid;
    logic [3:0] w4_a, w4_b;
    logic [7:0] w4_p;

    vedic_mult_pipe #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .in_a(w4_a), .in_b(w4_b), .in_signed(w4_in_signed), .out_valid(w4_out_valid),
        .out_ready(1'b1), .out_p(w4_p)
    );

    // Reference product: interpret operands as w-bit values, multiply as integers.
    function automatic longint ref_prod(input longint a, input longint b, input int w,
                                        input bit s);
        longint x;
        longint y;
        x = a;
        y = b;
        if (s && x[w-1]) x = x - (longint'(1) << w);
        if (s && y[w-1]) y = y - (longint'(1) << w);
        return x * y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard for the WIDTH = 8 instance: push on input transfer, pop on output transfer.
    logic [15:0] exp8_q[$];
    logic        stalled8;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp8_q.delete();
            stalled8 <= 1'b0;
        end else begin
            if (out_valid && out_ready && exp8_q.size() > 0) void'(exp8_q.pop_front());
            if (in_valid && in_ready)
                exp8_q.push_back(16'(ref_prod(in_a, in_b, 8, in_signed)));
            stalled8 <= out_valid && !out_ready;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled8) check("stall_hold_valid", {63'b0, out_valid}, 64'd1);
            if (out_valid) begin
                if (exp8_q.size() == 0) check("unexpected_output", {63'b0, out_valid}, 64'd0);
                else check("w8_model", out_p, exp8_q[0]);
            end
        end
    end

    // Scoreboard for the WIDTH = 4 instance.
    logic [7:0] exp4_q[$];
    int         w4_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp4_q.delete();
        end else begin
            if (w4_out_valid && exp4_q.size() > 0) void'(exp4_q.pop_front());
            if (w4_in_valid && w4_in_ready)
                exp4_q.push_back(8'(ref_prod(w4_a, w4_b, 4, w4_in_signed)));
        end
    end

    always @(negedge clk) begin
        if (rst_n && w4_out_valid) begin
            w4_count++;
            if (exp4_q.size() == 0) check("w4_unexpected", {63'b0, w4_out_valid}, 64'd0);
            else check("w4_model", w4_p, exp4_q[0]);
        end
    end

    // One WIDTH = 8 beat with literal expectation and exact 3-edge latency.
    task automatic dir8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp);
        @(negedge clk);
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat1"}, {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        check({name, "_lat2"}, {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        check({name, "_lat3"}, {63'b0, out_valid}, 64'd1);
        check({name, "_p"}, out_p, exp);
        @(negedge clk);
        check({name, "_one_cycle"}, {63'b0, out_valid}, 64'd0);
    endtask

    task automatic dir16(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [31:0] exp);
        @(negedge clk);
        w16_a = a; w16_b = b; w16_in_signed = s; w16_in_valid = 1'b1;
        @(posedge clk);
        #1 w16_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_v"}, {63'b0, w16_out_valid}, 64'd1);
        check({name, "_p"}, w16_p, exp);
    endtask

    logic [15:0] exp_a, exp_b, exp_c;
    int          streak;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
        w16_in_valid = 1'b0; w16_a = '0; w16_b = '0; w16_in_signed = 1'b0;
        w4_in_valid = 1'b0; w4_a = '0; w4_b = '0; w4_in_signed = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_valid", {63'b0, out_valid}, 64'd0);
        check("reset_p", out_p, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_valid", {63'b0, out_valid}, 64'd0);
        check("post_reset_p", out_p, 64'd0);
        check("post_reset_ready", {63'b0, in_ready}, 64'd1);

        // Corners
        dir8("u_ff_ff",   8'hFF, 8'hFF, 1'b0, 16'hFE01);
        dir8("s_m128sq",  8'h80, 8'h80, 1'b1, 16'h4000);
        dir8("s_m1_127",  8'hFF, 8'h7F, 1'b1, 16'hFF81);
        dir8("s_m128_127", 8'h80, 8'h7F, 1'b1, 16'hC080);
        dir8("u_80_80",   8'h80, 8'h80, 1'b0, 16'h4000);
        dir8("s_m3_5",    8'hFD, 8'h05, 1'b1, 16'hFFF1);

        // Full-rate random stream: beat i must be valid at the negedge 3 cycles later
        streak = 0;
        for (int i = 0; i < 259; i++) begin
            @(negedge clk);
            if (i >= 3 && out_valid) streak++;
            if (i < 256) begin
                in_a = 8'($urandom); in_b = 8'($urandom);
                in_signed = 1'($urandom); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("stream_full_rate", streak, 256);

        // Backpressure: three beats fill the pipe while the consumer is stalled
        exp_a = 16'(ref_prod(8'h9C, 8'h37, 8, 1'b1));
        exp_b = 16'(ref_prod(8'hF0, 8'h0F, 8, 1'b0));
        exp_c = 16'(ref_prod(8'h7F, 8'h81, 8, 1'b1));
        @(negedge clk);
        out_ready = 1'b0;
        in_a = 8'h9C; in_b = 8'h37; in_signed = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_a = 8'hF0; in_b = 8'h0F; in_signed = 1'b0;
        @(negedge clk);
        in_a = 8'h7F; in_b = 8'h81; in_signed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_in_ready", {63'b0, in_ready}, 64'd0);
            check("bp_hold_p", out_p, exp_a);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_second_v", {63'b0, out_valid}, 64'd1);
        check("bp_second_p", out_p, exp_b);
        @(negedge clk);
        check("bp_third_v", {63'b0, out_valid}, 64'd1);
        check("bp_third_p", out_p, exp_c);
        @(negedge clk);
        check("bp_drained", {63'b0, out_valid}, 64'd0);

        // Reset with two beats in flight
        @(negedge clk);
        in_a = 8'h12; in_b = 8'h34; in_signed = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_a = 8'hAB; in_b = 8'hCD; in_signed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", {63'b0, out_valid}, 64'd0);
        check("async_reset_p", out_p, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_stale_after_reset", {63'b0, out_valid}, 64'd0);
        end
        dir8("after_reset", 8'h0B, 8'h0D, 1'b0, 16'h008F);

        // WIDTH = 16
        dir16("w16_u_max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        dir16("w16_s_min", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
        dir16("w16_s_mix", 16'hFFFE, 16'h1234, 1'b1, 32'hFFFFDB98);

        // WIDTH = 4 exhaustive, both modes
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            w4_a = 4'(i); w4_b = 4'(i >> 4); w4_in_signed = 1'(i >> 8); w4_in_valid = 1'b1;
        end
        @(negedge clk);
        w4_in_valid = 1'b0;
        repeat (5) @(negedge clk);

        check("w4_count", w4_count, 512);
        check("w8_drain", exp8_q.size(), 0);
        check("w4_drain", exp4_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vedic_mult_pipe.md
# vedic_mult_pipe

Parametrised, pipelined successor to the team's combinational 8x8 Vedic (Urdhva-Tiryakbhyam) multiplier. Accepts WIDTH x WIDTH operands with a per-transaction signed/unsigned mode over a valid/ready handshake and returns a 2*WIDTH product after a fixed 3-cycle latency. Sustains one product per cycle under full backpressure support. It sits between operand sources, such as the MAC datapath and the DSP front-end, and any consumer that may stall.

## Interface
- WIDTH, 8: operand width. Must be a power of two, 4..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_p  out  2*WIDTH  product.

## Operation
- **Transfers.** An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- **Global advance.** adv = !out_valid || out_ready. in_ready = adv, combinationally. All stage registers and valid bits update only when adv=1.
- **S1 (capture).**
  - Register the operand magnitudes: |a| and |b| when in_signed=1, the raw values otherwise.
  - Register neg = in_signed & (a[MSB] ^ b[MSB]), plus v1.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). It fits in WIDTH unsigned bits and needs no special case.
- **S2 (partial products).**
  - Split each magnitude into halves H and L.
  - Compute the four half-width products LL, HL, LH, HH with the recursive combinational Vedic core.
  - Register the four products, neg, and v2.
- **S3 (accumulate).**
  - mid = HL + LH, computed at WIDTH+1 bits.
  - p = HH<<WIDTH + mid<<(WIDTH/2) + LL, computed at 2*WIDTH bits.
  - When neg=1, register -p (two's complement, 2*WIDTH bits); otherwise register p. Also register v3.
  - out_p is the S3 register and out_valid = v3.
- **Arithmetic.** Results are exact with no truncation. The unsigned maximum (2^WIDTH-1)^2 and the signed extreme (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) both fit in 2*WIDTH bits.
- **Bubbles.** A bubble (in_valid=0 while adv=1) propagates as a cleared valid bit. Bubbles are not compressed while adv=1.
- **Stall.** While out_valid && !out_ready, all stages hold, in_ready=0, and out_p is stable.
- **Reset.** Asynchronous assertion clears v1, v2 and v3 and all data registers to 0. out_valid=0 and out_p=0 during reset and on the first cycle after it. In-flight beats are discarded, not flushed.

## Timing
- Latency is 3 clk edges from an accepted input to out_valid, with no stalls.
- Throughput is 1 beat per cycle while out_ready=1.
- in_ready has a combinational path from out_ready only; there is no path from in_valid.
- out_p and out_valid are registered outputs.
- If out_ready drops for N cycles, the pipeline freezes for exactly N cycles. No beat is lost or duplicated, and order is preserved.
- An input and an output transfer in the same cycle are legal and required at full rate.
- Reset deassertion is synchronised externally. The block samples normally from the first edge after rst_n rises.

## Structure
- Shared package vedic_pkg:
  - VEDIC_MIN_W = 4 and VEDIC_MAX_W = 32.
  - A function for two's-complement magnitude.
  - An elaboration check that WIDTH is a power of two.
- Sub-module vedic_nxn_comb #(W): purely combinational W x W unsigned Vedic product.
  - Recursive generate down to a 2x2 gate-level leaf built from half adders.
  - Instantiated four times at W = WIDTH/2 in S2.
- The S3 adder tree is inline in vedic_mult_pipe.
- Target size is about 200-300 lines including the core.

## Test plan
- **Unsigned corner, WIDTH=8.** Drive a=0xFF, b=0xFF, in_signed=0 with out_ready=1. Required: out_p=0xFE01 exactly 3 cycles later, and out_valid high for 1 cycle.
- **Signed corners, WIDTH=8.**
  - (-128)*(-128) requires 0x4000.
  - (-1)*127 requires 0xFF81.
  - (-128)*127 requires 0xC080.
  - In unsigned mode, 0x80*0x80 requires 0x4000.
- **Full-rate stream.** Send 256 back-to-back random beats with mixed modes and out_ready=1. Required: one result per cycle, in order, matching a reference model.
- **Backpressure.** Hold out_ready=0 for 5 cycles with 3 beats in flight. Required:
  - in_ready=0 throughout the stall.
  - out_p held stable.
  - After release, the 3 results appear on consecutive cycles with no loss.
- **Reset mid-operation.** Assert rst_n=0 with 2 beats in flight. Required:
  - out_valid=0 and out_p=0 immediately, asynchronously.
  - No stale result after rst_n rises.
  - The next accepted beat appears 3 cycles after it is accepted.
- **WIDTH=16 and WIDTH=4 elaboration.** Required:
  - WIDTH=16: 0xFFFF*0xFFFF=0xFFFE0001 (unsigned) and (-32768)*(-32768)=0x40000000 (signed).
  - WIDTH=4: exhaustive 256 pairs in both modes, all correct.
